// File: rtl/sar_out_pkg.sv
// Shared defaults and helpers for the SAR output buffer.
//   SAR_WIDTH    : default SAR result width in bits
//   SAR_DEPTH    : default output FIFO depth (power of two, >= 2)
//   SAR_AVG_LOG2 : default log2 of the averaging block length (0 = off)
//   clog2()      : ceiling log2, usable in constant expressions
package sar_out_pkg;

    localparam int SAR_WIDTH    = 9;
    localparam int SAR_DEPTH    = 4;
    localparam int SAR_AVG_LOG2 = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sar_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge pulse generator.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous level input
//   pulse : one-cycle pulse after each synchronized rising edge of d
// The history flop resets to 1 and is held at 1 until the synchronizer has
// refilled from the live input, so a level that is already high when reset
// is released never produces a pulse.
module sar_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic       ff1;
    logic       ff2;
    logic       hist;
    logic [1:0] prime;  // fills with ones: ff2 carries the real input once prime[1] is set

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1   <= 1'b0;
            ff2   <= 1'b0;
            hist  <= 1'b1;
            prime <= 2'b00;
        end else begin
            ff1   <= d;
            ff2   <= ff1;
            prime <= {prime[0], 1'b1};
            hist  <= prime[1] ? ff2 : 1'b1;
        end
    end

    assign pulse = ff2 & ~hist;

endmodule

// File: rtl/sar_out_buffer.sv
// SAR result capture, optional block averaging and first-word-fall-through
// output FIFO.
//   CKS        : system clock (rising edge)
//   EN         : asynchronous active-low reset
//   FINAL      : conversion-done flag, asynchronous to CKS
//   SWP        : SAR result, index 0 is MSB
//   AVG_EN     : averaging mode request, taken at block boundaries
//   RD_READY   : consumer accepts the head entry
//   CLR_OVF    : clears the overflow flag
//   CKO        : FINAL AND CKS, combinational
//   DATA       : FIFO head entry, index 0 is MSB
//   DATA_VALID : FIFO non-empty
//   LEVEL      : FIFO occupancy
//   OVF        : sticky flag, a sample was dropped
// Read handshake: an entry is popped on a rising edge where DATA_VALID and
// RD_READY are both 1; DATA shows the next entry from the following cycle.
module sar_out_buffer
    import sar_out_pkg::*;
#(
    parameter int WIDTH    = SAR_WIDTH,
    parameter int DEPTH    = SAR_DEPTH,
    parameter int AVG_LOG2 = SAR_AVG_LOG2
) (
    input  logic                      CKS,
    input  logic                      EN,
    input  logic                      FINAL,
    input  logic [0:WIDTH-1]          SWP,
    input  logic                      AVG_EN,
    input  logic                      RD_READY,
    input  logic                      CLR_OVF,
    output logic                      CKO,
    output logic [0:WIDTH-1]          DATA,
    output logic                      DATA_VALID,
    output logic [clog2(DEPTH+1)-1:0] LEVEL,
    output logic                      OVF
);

    localparam int PW = clog2(DEPTH);
    localparam int LW = clog2(DEPTH + 1);
    localparam int AW = WIDTH + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic          AVG_ON   = (AVG_LOG2 > 0);

    logic             cap;
    logic [WIDTH-1:0] sample;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    sum;
    logic [CW-1:0]    cnt;
    logic             avg_mode;
    logic             use_avg;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             ovf_evt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_next;
    logic [WIDTH-1:0] data_q;
    logic             ovf_q;

    sar_sync_edge u_sync (
        .clk   (CKS),
        .rst_n (EN),
        .d     (FINAL),
        .pulse (cap)
    );

    assign sample = SWP;

    // Mid-block the mode is the latched one; at a block boundary the live
    // request applies directly so the first sample of a block is not lost.
    assign use_avg = AVG_ON && ((cnt == '0) ? AVG_EN : avg_mode);
    assign sum     = acc + AW'(sample);

    always_comb begin
        push      = 1'b0;
        push_data = sample;
        if (cap) begin
            if (use_avg) begin
                push      = (cnt == CNT_LAST);
                push_data = WIDTH'(sum >> AVG_LOG2);
            end else begin
                push = 1'b1;
            end
        end
    end

    assign full    = (level == LVL_FULL);
    assign pop     = DATA_VALID & RD_READY;
    assign push_ok = push & (~full | pop);
    assign ovf_evt = push & full & ~pop;
    assign rd_next = rd_ptr + PW'(1);

    always_comb begin
        level_next = level;
        case ({push_ok, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Storage carries no reset; only entries below LEVEL are ever observed.
    always_ff @(posedge CKS) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CKS or negedge EN) begin
        if (!EN) begin
            acc      <= '0;
            cnt      <= '0;
            avg_mode <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (cnt == '0) avg_mode <= AVG_EN & AVG_ON;

            if (cap && use_avg) begin
                if (cnt == CNT_LAST) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CW'(1);
                end
            end

            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_next;
            level <= level_next;

            // Registered head: refilled on pop, or loaded when pushing into
            // an empty FIFO; otherwise it holds its last value.
            if (pop) begin
                if (level == LW'(1)) begin
                    if (push_ok) data_q <= push_data;
                end else begin
                    data_q <= mem[rd_next];
                end
            end else if (push_ok && level == '0) begin
                data_q <= push_data;
            end

            if (ovf_evt)      ovf_q <= 1'b1;
            else if (CLR_OVF) ovf_q <= 1'b0;
        end
    end

    assign CKO        = FINAL & CKS;
    assign DATA       = data_q;
    assign DATA_VALID = (level != '0);
    assign LEVEL      = level;
    assign OVF        = ovf_q;

endmodule

// File: tb/tb_sar_out_buffer.sv
// Directed bench for sar_out_buffer with a scoreboard queue of expected FIFO
// entries and a small behavioural model of averaging, occupancy and overflow.
module tb_sar_out_buffer;

    localparam int W = 9;

    logic         CKS;
    logic         EN;
    logic         FINAL;
    logic [0:W-1] SWP;
    logic         AVG_EN;
    logic         RD_READY;
    logic         CLR_OVF;
    logic         CKO;
    logic [0:W-1] DATA;
    logic         DATA_VALID;
    logic [2:0]   LEVEL;
    logic         OVF;

    sar_out_buffer dut (
        .CKS        (CKS),
        .EN         (EN),
        .FINAL      (FINAL),
        .SWP        (SWP),
        .AVG_EN     (AVG_EN),
        .RD_READY   (RD_READY),
        .CLR_OVF    (CLR_OVF),
        .CKO        (CKO),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .LEVEL      (LEVEL),
        .OVF        (OVF)
    );

    // clock / reset
    initial CKS = 1'b0;
    always #5 CKS = ~CKS;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    // scoreboard and model state
    logic [W-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int m_level     = 0;
    int m_acc       = 0;
    int m_cnt       = 0;
    bit m_mode      = 0;
    bit m_ovf       = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_level = 0;
        m_acc   = 0;
        m_cnt   = 0;
        m_mode  = 0;
        m_ovf   = 0;
    endtask

    task automatic model_capture(input logic [W-1:0] s, input bit rd, input bit clr);
        bit           pushing;
        bit           ovf_evt;
        logic [W-1:0] v;
        pushing = 0;
        v       = s;
        if (m_cnt == 0) m_mode = AVG_EN;
        if (m_mode) begin
            m_acc += int'(s);
            m_cnt++;
            if (m_cnt == 4) begin
                v       = W'(m_acc / 4);
                pushing = 1;
                m_acc   = 0;
                m_cnt   = 0;
            end
        end else begin
            pushing = 1;
        end
        ovf_evt = pushing && (m_level == 4) && !rd;
        if (pushing && !ovf_evt) begin
            exp_q.push_back(v);
            if (!rd) m_level++;
        end else if (rd) begin
            m_level--;
        end
        if (ovf_evt)  m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    // driver: 2-cycle FINAL pulse; capture lands on the 3rd rising edge.
    // clr holds CLR_OVF up to and including the capture edge; rd asserts
    // RD_READY only on the capture edge.
    task automatic fire(input logic [W-1:0] s, input bit clr, input bit rd);
        @(negedge CKS);
        SWP   = s;
        FINAL = 1'b1;
        if (clr) CLR_OVF = 1'b1;
        @(negedge CKS);
        @(negedge CKS);
        FINAL = 1'b0;
        if (rd) begin
            check("pop_head", DATA, exp_q.pop_front());
            RD_READY = 1'b1;
        end
        @(negedge CKS);
        CLR_OVF  = 1'b0;
        RD_READY = 1'b0;
        model_capture(s, rd, clr);
        repeat (2) @(negedge CKS);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            @(negedge CKS);
            check("valid", DATA_VALID, 1);
            check("data", DATA, exp_q.pop_front());
            RD_READY = 1'b1;
            @(negedge CKS);
            RD_READY = 1'b0;
            m_level--;
        end
        @(negedge CKS);
        check("empty_valid", DATA_VALID, 0);
        check("empty_level", LEVEL, 0);
    endtask

    initial begin
        EN       = 1'b0;
        FINAL    = 1'b0;
        SWP      = '0;
        AVG_EN   = 1'b0;
        RD_READY = 1'b0;
        CLR_OVF  = 1'b0;
        #1;
        check("rst_data", DATA, 0);
        check("rst_valid", DATA_VALID, 0);
        check("rst_level", LEVEL, 0);
        check("rst_ovf", OVF, 0);
        FINAL = 1'b1;
        @(posedge CKS); #1;
        check("cko_rst_hi", CKO, FINAL & CKS);
        @(negedge CKS); #1;
        check("cko_rst_lo", CKO, FINAL & CKS);
        FINAL = 1'b0;
        @(negedge CKS);
        EN = 1'b1;
        repeat (3) @(negedge CKS);

        // plain capture, fill to full, ordered read-out
        fire(9'h1FF, 0, 0);
        fire(9'h000, 0, 0);
        fire(9'h155, 0, 0);
        fire(9'h0AA, 0, 0);
        check("fill_level", LEVEL, m_level);
        check("fill_ovf", OVF, 0);
        drain();
        check("drain_ovf", OVF, 0);

        // overflow drop, overflow coinciding with clear, then clear
        fire(9'h1FF, 0, 0);
        fire(9'h000, 0, 0);
        fire(9'h155, 0, 0);
        fire(9'h0AA, 0, 0);
        fire(9'h123, 0, 0);
        check("ovf_set", OVF, m_ovf);
        check("ovf_level", LEVEL, 4);
        fire(9'h0AB, 1, 0);
        check("ovf_clr_collide", OVF, m_ovf);
        @(negedge CKS);
        CLR_OVF = 1'b1;
        @(negedge CKS);
        CLR_OVF = 1'b0;
        m_ovf = 0;
        check("ovf_cleared", OVF, m_ovf);
        drain();

        // push and pop on the same edge while full
        fire(9'h011, 0, 0);
        fire(9'h022, 0, 0);
        fire(9'h033, 0, 0);
        fire(9'h044, 0, 0);
        fire(9'h055, 0, 1);
        check("pp_level", LEVEL, 4);
        check("pp_ovf", OVF, 0);
        drain();

        // averaging; mode change mid-block only applies after the block
        AVG_EN = 1'b1;
        fire(9'd10, 0, 0);
        fire(9'd11, 0, 0);
        fire(9'd12, 0, 0);
        check("avg_partial_level", LEVEL, 0);
        fire(9'd14, 0, 0);
        check("avg_level1", LEVEL, m_level);
        check("avg_data1", DATA, exp_q[0]);
        fire(9'h1FF, 0, 0);
        fire(9'h1FF, 0, 0);
        AVG_EN = 1'b0;
        fire(9'h1FF, 0, 0);
        fire(9'h1FF, 0, 0);
        check("avg_level2", LEVEL, m_level);

        // reset mid-block with FINAL high across release
        AVG_EN = 1'b1;
        fire(9'd200, 0, 0);
        fire(9'd210, 0, 0);
        @(negedge CKS);
        FINAL = 1'b1;
        EN    = 1'b0;
        #1;
        check("mid_rst_data", DATA, 0);
        check("mid_rst_valid", DATA_VALID, 0);
        check("mid_rst_level", LEVEL, 0);
        check("mid_rst_ovf", OVF, 0);
        model_reset();
        repeat (2) @(negedge CKS);
        EN = 1'b1;
        repeat (6) @(negedge CKS);
        check("rel_no_capture", LEVEL, 0);
        FINAL = 1'b0;
        repeat (3) @(negedge CKS);
        fire(9'd100, 0, 0);
        fire(9'd101, 0, 0);
        fire(9'd102, 0, 0);
        fire(9'd103, 0, 0);
        check("fresh_avg_level", LEVEL, m_level);
        drain();

        // sub-cycle glitch between rising edges, then a 2-cycle pulse
        AVG_EN = 1'b0;
        repeat (2) @(negedge CKS);
        @(posedge CKS);
        #2;
        FINAL = 1'b1;
        #1;
        check("cko_glitch", CKO, FINAL & CKS);
        #1;
        FINAL = 1'b0;
        repeat (5) @(negedge CKS);
        check("glitch_level", LEVEL, 0);
        fire(9'h0F0, 0, 0);
        repeat (4) @(negedge CKS);
        check("one_capture", LEVEL, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
